// File: rtl/mdu_pkg.sv
// Shared encodings, widths and latency defaults for the MDU issue/interlock logic.
package mdu_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CMD_W       = 4;
  localparam int unsigned OP_W        = 2;
  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 9;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 4'd0,
    CMD_MULT  = 4'd1,
    CMD_MULTU = 4'd2,
    CMD_DIV   = 4'd3,
    CMD_DIVU  = 4'd4,
    CMD_MADD  = 4'd5,
    CMD_MTHI  = 4'd6,
    CMD_MTLO  = 4'd7,
    CMD_MFHI  = 4'd8,
    CMD_MFLO  = 4'd9
  } mdu_cmd_e;

  typedef enum logic [OP_W-1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mdu_state_e;

  // Request lines toward the MDU, built together and fanned out to the interface.
  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [OP_W-1:0]   op;
    logic              start;
    logic              we;
    logic              hilo;
    logic              madd;
  } mdu_req_t;

  // Codes above MFLO are reserved and behave like NONE.
  function automatic logic cmd_is_mdu(input logic [CMD_W-1:0] cmd);
    return (cmd != CMD_NONE) && (cmd <= CMD_MFLO);
  endfunction

endpackage

// File: rtl/mdu_issue_if.sv
// Request/response bundle between the issue controller and the multiply/divide unit.
interface mdu_issue_if;
  import mdu_pkg::*;

  logic [DATA_W-1:0] mdu_d1;
  logic [DATA_W-1:0] mdu_d2;
  logic [OP_W-1:0]   mdu_op;
  logic              mdu_start;
  logic              mdu_we;
  logic              mdu_hilo;
  logic              mdu_madd;
  logic              mdu_if_exception;
  logic              mdu_busy;
  logic [DATA_W-1:0] mdu_hi;
  logic [DATA_W-1:0] mdu_lo;

  modport master (
    output mdu_d1, mdu_d2, mdu_op, mdu_start, mdu_we, mdu_hilo, mdu_madd, mdu_if_exception,
    input  mdu_busy, mdu_hi, mdu_lo
  );

  modport slave (
    input  mdu_d1, mdu_d2, mdu_op, mdu_start, mdu_we, mdu_hilo, mdu_madd, mdu_if_exception,
    output mdu_busy, mdu_hi, mdu_lo
  );

endinterface

// File: rtl/mdu_lat_cnt.sv
// Loadable down-counter that stops at zero; gives the minimum remaining MDU latency.
module mdu_lat_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement so a back-to-back issue restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue.sv
// Execute-stage issue/interlock controller for the multiply/divide unit:
// drives MDU requests, stalls on MDU hazards and returns HI/LO for MFHI/MFLO.
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [CMD_W-1:0]  ex_cmd,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic              ex_exc,
  input  logic              flush,
  output logic              stall_o,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_valid,
  mdu_issue_if.master       mdu
);

  mdu_state_e       state_q;
  mdu_op_e          op_sel;
  mdu_req_t         req;
  logic             is_arith;
  logic             is_madd;
  logic             is_mt;
  logic             is_mf;
  logic             sel_lo;
  logic             is_div;
  logic             cnt_zero;
  logic             done;
  logic             go;
  logic             issue;
  logic [CNT_W-1:0] load_val;

  // Command decode.
  always_comb begin
    is_arith = 1'b0;
    is_madd  = 1'b0;
    is_mt    = 1'b0;
    is_mf    = 1'b0;
    sel_lo   = 1'b0;
    is_div   = 1'b0;
    op_sel   = OP_MULTU;
    case (ex_cmd)
      CMD_MULT:  begin is_arith = 1'b1; op_sel = OP_MULT;  end
      CMD_MULTU: begin is_arith = 1'b1; op_sel = OP_MULTU; end
      CMD_DIV:   begin is_arith = 1'b1; op_sel = OP_DIV;   is_div = 1'b1; end
      CMD_DIVU:  begin is_arith = 1'b1; op_sel = OP_DIVU;  is_div = 1'b1; end
      CMD_MADD:  is_madd = 1'b1;
      CMD_MTHI:  is_mt = 1'b1;
      CMD_MTLO:  begin is_mt = 1'b1; sel_lo = 1'b1; end
      CMD_MFHI:  is_mf = 1'b1;
      CMD_MFLO:  begin is_mf = 1'b1; sel_lo = 1'b1; end
      default:   ;
    endcase
  end

  // The counter is only a lower bound; Busy can extend the wait indefinitely.
  assign done     = cnt_zero & ~mdu.mdu_busy;
  assign stall_o  = (state_q == ST_WAIT) & ~done & ex_valid & cmd_is_mdu(ex_cmd);
  assign go       = ex_valid & ~ex_exc & ~flush & ~stall_o;
  assign issue    = go & (is_arith | is_madd);
  assign load_val = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  mdu_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (Clk),
    .rst_n      (resetn),
    .load_i     (issue),
    .load_val_i (load_val),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  // Exiting WAIT and issuing the next operation may happen on the same edge.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue)          state_q <= ST_WAIT;
        ST_WAIT: if (done && !issue) state_q <= ST_IDLE;
        default:                     state_q <= ST_IDLE;
      endcase
    end
  end

  // Request strobes and operands, all held at zero unless the instruction goes.
  always_comb begin
    req = '0;
    if (go) begin
      if (is_arith || is_madd) begin
        req.d1 = ex_rs;
        req.d2 = ex_rt;
      end
      if (is_arith) begin
        req.start = 1'b1;
        req.op    = op_sel;
      end
      if (is_madd) begin
        req.madd = 1'b1;
      end
      if (is_mt) begin
        req.we   = 1'b1;
        req.d1   = ex_rs;
        req.hilo = sel_lo;
      end
    end
  end

  assign mdu.mdu_d1           = req.d1;
  assign mdu.mdu_d2           = req.d2;
  assign mdu.mdu_op           = req.op;
  assign mdu.mdu_start        = req.start;
  assign mdu.mdu_we           = req.we;
  assign mdu.mdu_hilo         = req.hilo;
  assign mdu.mdu_madd         = req.madd;
  assign mdu.mdu_if_exception = ex_exc | flush;

  assign mf_valid = go & is_mf;
  assign mf_data  = (ex_valid && is_mf) ? (sel_lo ? mdu.mdu_lo : mdu.mdu_hi) : '0;

endmodule

// File: tb/tb_mdu_issue.sv
// Bench for mdu_issue: behavioural MDU, timeline-based interlock model checked every cycle,
// and directed instruction sequences with hand-computed results.
module tb_mdu_issue;
  import mdu_pkg::*;

  localparam int MUL_L = 4;
  localparam int DIV_L = 9;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [3:0]  ex_cmd;
  logic [31:0] ex_rs, ex_rt;
  logic        ex_exc, flush;
  logic        stall_o;
  logic [31:0] mf_data;
  logic        mf_valid;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_issue_if mif();

  mdu_issue #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(4)) dut (
    .Clk      (Clk),
    .resetn   (resetn),
    .ex_valid (ex_valid),
    .ex_cmd   (ex_cmd),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .ex_exc   (ex_exc),
    .flush    (flush),
    .stall_o  (stall_o),
    .mf_data  (mf_data),
    .mf_valid (mf_valid),
    .mdu      (mif)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural MDU ----------------
  int          extra_busy = 0;
  int          m_rem;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  function automatic logic [63:0] mdu_calc(input logic [1:0] op, input logic madd,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] acc);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (madd) return acc + 64'(sa * sb);
    case (op)
      2'b00: return {32'h0, a} * {32'h0, b};
      2'b01: return 64'(sa * sb);
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else begin
      if (mif.mdu_start || mif.mdu_madd) begin
        m_rem  <= (mif.mdu_start && mif.mdu_op[1] ? DIV_L : MUL_L) + extra_busy;
        m_pend <= mdu_calc(mif.mdu_op, mif.mdu_madd, mif.mdu_d1, mif.mdu_d2, {m_hi, m_lo});
      end else if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end
      if (mif.mdu_we) begin
        if (mif.mdu_hilo) m_lo <= mif.mdu_d1;
        else              m_hi <= mif.mdu_d1;
      end
    end
  end

  assign mif.mdu_busy = (m_rem != 0);
  assign mif.mdu_hi   = m_hi;
  assign mif.mdu_lo   = m_lo;

  // ---------------- interlock model: MDU is free from cycle free_at on, once Busy drops ----------------
  int cyc     = 0;
  int free_at = 0;
  int exp_lat = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk or negedge resetn) begin
    if (!resetn)           free_at <= 0;
    else if (exp_lat != 0) free_at <= cyc + 1 + exp_lat;
  end

  always @(negedge Clk) begin : compare
    logic        mdu_cmd, blocked, e_go, arith, madd, mt, mf, lo;
    logic [1:0]  op;
    int          lat;
    arith = 1'b0; madd = 1'b0; mt = 1'b0; mf = 1'b0; lo = 1'b0; op = 2'b00; lat = 0;
    case (ex_cmd)
      4'd1: begin arith = 1'b1; op = 2'b01; lat = MUL_L; end
      4'd2: begin arith = 1'b1; op = 2'b00; lat = MUL_L; end
      4'd3: begin arith = 1'b1; op = 2'b11; lat = DIV_L; end
      4'd4: begin arith = 1'b1; op = 2'b10; lat = DIV_L; end
      4'd5: begin madd = 1'b1; lat = MUL_L; end
      4'd6: mt = 1'b1;
      4'd7: begin mt = 1'b1; lo = 1'b1; end
      4'd8: mf = 1'b1;
      4'd9: begin mf = 1'b1; lo = 1'b1; end
      default: ;
    endcase
    mdu_cmd = (ex_cmd >= 4'd1) && (ex_cmd <= 4'd9);
    blocked = ex_valid && mdu_cmd && ((cyc < free_at) || mif.mdu_busy);
    e_go    = ex_valid && !ex_exc && !flush && !blocked;
    exp_lat = e_go ? lat : 0;

    chk("stall_o",   32'(stall_o),            32'(blocked));
    chk("start",     32'(mif.mdu_start),      32'(e_go && arith));
    chk("madd",      32'(mif.mdu_madd),       32'(e_go && madd));
    chk("we",        32'(mif.mdu_we),         32'(e_go && mt));
    chk("hilo",      32'(mif.mdu_hilo),       32'(e_go && mt && lo));
    chk("op",        32'(mif.mdu_op),         32'((e_go && arith) ? op : 2'b00));
    chk("d1",        mif.mdu_d1,              (e_go && (arith || madd || mt)) ? ex_rs : 32'h0);
    chk("d2",        mif.mdu_d2,              (e_go && (arith || madd)) ? ex_rt : 32'h0);
    chk("if_exc",    32'(mif.mdu_if_exception), 32'(ex_exc || flush));
    chk("mf_valid",  32'(mf_valid),           32'(e_go && mf));
    chk("mf_data",   mf_data,                 (ex_valid && mf) ? (lo ? m_lo : m_hi) : 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ex_valid = 1'b0; ex_cmd = 4'd0; ex_rs = '0; ex_rt = '0; ex_exc = 1'b0; flush = 1'b0;
  endtask

  // Present one instruction and hold it until it leaves EX; reports stall cycles and MF result.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls, output logic [31:0] mf, output logic mfv,
                       output logic strobe);
    ex_valid = 1'b1; ex_cmd = cmd; ex_rs = rs; ex_rt = rt; ex_exc = 1'b0; flush = 1'b0;
    stalls = 0; mf = '0; mfv = 1'b0; strobe = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (!stall_o) begin
        mf     = mf_data;
        mfv    = mf_valid;
        strobe = mif.mdu_start | mif.mdu_madd | mif.mdu_we;
        @(posedge Clk); #1;
        idle();
        return;
      end
      stalls++;
      @(posedge Clk); #1;
    end
    n_tests++; n_fail++;
    $display("FAIL issue_timeout: cmd %0d still stalled after 40 cycles", cmd);
    idle();
  endtask

  int          st;
  logic [31:0] mf;
  logic        mfv, sb;

  initial begin
    idle();
    resetn = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_cnt",   32'(dut.u_cnt.cnt_q), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    resetn = 1'b1;
    @(posedge Clk); #1;

    // MULT -3 * 7, dependent MFLO
    issue(CMD_MULT, 32'hFFFF_FFFD, 32'd7, st, mf, mfv, sb);
    chk("mult_nostall", 32'(st), 32'd0);
    chk("mult_start",   32'(sb), 32'd1);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("mult_stall",   32'(st), 32'd4);
    chk("mult_lo",      mf, 32'hFFFF_FFEB);
    chk("mult_mfv",     32'(mfv), 32'd1);

    // DIVU 100 / 7
    issue(CMD_DIVU, 32'd100, 32'd7, st, mf, mfv, sb);
    issue(CMD_MFHI, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("divu_stall", 32'(st), 32'd9);
    chk("divu_hi",    mf, 32'd2);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("divu_lo",    mf, 32'd14);

    // MTLO then MFLO
    issue(CMD_MTLO, 32'h1234, 32'h0, st, mf, mfv, sb);
    chk("mtlo_stall", 32'(st), 32'd0);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("mtlo_stall2", 32'(st), 32'd0);
    chk("mtlo_lo",     mf, 32'h1234);

    // MULT with exception: cancelled
    ex_valid = 1'b1; ex_cmd = CMD_MULT; ex_rs = 32'd5; ex_rt = 32'd5; ex_exc = 1'b1;
    @(negedge Clk);
    chk("exc_start", 32'(mif.mdu_start), 32'd0);
    chk("exc_flag",  32'(mif.mdu_if_exception), 32'd1);
    @(posedge Clk); #1;
    idle();
    chk("exc_state", 32'(dut.state_q), 32'(ST_IDLE));
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("exc_stall", 32'(st), 32'd0);
    chk("exc_lo",    mf, 32'h1234);

    // DIV in flight, flushed MULT for two cycles, then the MULT issues with no bubble
    issue(CMD_DIV, 32'hFFFF_FFEC, 32'd3, st, mf, mfv, sb);
    ex_valid = 1'b1; ex_cmd = CMD_MULT; ex_rs = 32'd6; ex_rt = 32'd7; flush = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      chk("flush_stall", 32'(stall_o), 32'd1);
      @(posedge Clk); #1;
    end
    issue(CMD_MULT, 32'd6, 32'd7, st, mf, mfv, sb);
    chk("b2b_stall", 32'(st), 32'd7);
    chk("b2b_start", 32'(sb), 32'd1);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("b2b_mstall", 32'(st), 32'd4);
    chk("b2b_lo",     mf, 32'd42);

    // MADD accumulates -1*2 onto 42
    issue(CMD_MADD, 32'hFFFF_FFFF, 32'd2, st, mf, mfv, sb);
    chk("madd_strobe", 32'(sb), 32'd1);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("madd_stall", 32'(st), 32'd4);
    chk("madd_lo",    mf, 32'd40);
    issue(CMD_MFHI, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("madd_hi",    mf, 32'd0);

    // Busy outlasting the counter keeps the stall
    extra_busy = 3;
    issue(CMD_MULTU, 32'hFFFF_FFFF, 32'd2, st, mf, mfv, sb);
    issue(CMD_MFHI, 32'h0, 32'h0, st, mf, mfv, sb);
    extra_busy = 0;
    chk("busy_stall", 32'(st), 32'd7);
    chk("multu_hi",   mf, 32'd1);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("multu_lo",   mf, 32'hFFFF_FFFE);

    // Reserved code and NONE pass through during WAIT
    issue(CMD_DIVU, 32'd9, 32'd3, st, mf, mfv, sb);
    issue(4'd12, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("rsv_stall",  32'(st), 32'd0);
    issue(CMD_NONE, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("none_stall", 32'(st), 32'd0);
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("divu2_stall", 32'(st), 32'd7);
    chk("divu2_lo",    mf, 32'd3);

    // Asynchronous reset in the second WAIT cycle
    issue(CMD_DIV, 32'd50, 32'd5, st, mf, mfv, sb);
    @(posedge Clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("arst_cnt",   32'(dut.u_cnt.cnt_q), 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    resetn = 1'b1;
    issue(CMD_MFLO, 32'h0, 32'h0, st, mf, mfv, sb);
    chk("arst_nostall", 32'(st), 32'd0);

    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
# mdu_issue

Issue and interlock controller on the requesting side of the multiply/divide unit. It sits in the execute stage between the decoded instruction and the MDU. It turns MULT/MULTU/DIV/DIVU/MADD/MTHI/MTLO into the MDU's D1/D2/Op/Start/We/HiLo/madd request lines, and cancels requests on exceptions. It tracks operation latency with its own counter plus the MDU Busy flag, stalls the pipeline on MDU hazards, and returns HI/LO for MFHI/MFLO.

## Interface
Parameters:
- MUL_LAT, 4, cycles Busy stays high after a MULT/MULTU/MADD start edge
- DIV_LAT, 9, cycles Busy stays high after a DIV/DIVU start edge
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > DIV_LAT

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_cmd  in  4  MDU command, encoded per mdu_pkg
- ex_rs, ex_rt  in  32  source operands
- ex_exc  in  1  the EX instruction is excepting this cycle
- flush  in  1  pipeline flush this cycle
- stall_o  out  1  freeze EX and all earlier stages
- mf_data  out  32  HI or LO value for MFHI/MFLO
- mf_valid  out  1  mf_data is valid this cycle
- mdu_d1, mdu_d2  out  32  operands to the MDU
- mdu_op  out  2  MULTU=00, MULT=01, DIVU=10, DIV=11
- mdu_start, mdu_we, mdu_hilo, mdu_madd  out  1  MDU request strobes; mdu_hilo: 0=HI, 1=LO
- mdu_if_exception  out  1  equals ex_exc | flush
- mdu_busy  in  1  MDU Busy
- mdu_hi, mdu_lo  in  32  MDU HI and LO

## Operation
- Command codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MTHI=6, MTLO=7, MFHI=8, MFLO=9. Codes 10–15 are treated as NONE.
- Define `go = ex_valid & !ex_exc & !flush & !stall_o`. All MDU strobes are combinational, gated by `go`, and 0 otherwise.
- Arithmetic commands drive the following when `go`:
  - mdu_start=1, mdu_d1=ex_rs, mdu_d2=ex_rt, mdu_op per the mapping above.
  - MADD instead drives mdu_madd=1 and mdu_start=0, with mdu_op=00.
- MTHI/MTLO drive mdu_we=1, mdu_d1=ex_rs, and mdu_hilo=0 or 1. There is no wait state, since Busy never rises for a write.
- MFHI/MFLO drive mf_data=mdu_hi or mdu_lo and mf_valid=go.
  - With any other command, mf_data=0.
- Divide-by-zero is still issued; the resulting HI/LO are architecturally unpredictable.
- The FSM has two states, IDLE and WAIT.
  - IDLE → WAIT on an arithmetic or MADD `go`. The counter loads MUL_LAT or DIV_LAT.
  - In WAIT, the counter decrements each cycle while it is above 0.
  - Define `done = (cnt==0) & !mdu_busy`. WAIT → IDLE when `done`.
- stall_o is combinational: `stall_o = (state==WAIT) & !done & ex_valid & (ex_cmd != NONE)`.
  - Non-MDU instructions are never stalled.
- A command waiting in EX issues in the same cycle that `done` rises, with zero bubble. That cycle is both the WAIT→IDLE exit and the new IDLE→WAIT entry.
- flush or ex_exc while in WAIT does not cancel the in-flight MDU operation; the unit stays in WAIT until `done`.
- In-flight MDU operations are not tracked across reset. The MDU has its own reset.

## Timing
- Reset (asynchronous, resetn=0): state=IDLE, cnt=0. All outputs are 0 while ex_valid=0.
- With a start at edge T:
  - mdu_busy is high from T through T+MUL_LAT (or T+DIV_LAT).
  - stall_o is high in the cycles after T, up to the cycle before `done`.
  - A dependent MFLO receives mf_valid in cycle T+MUL_LAT+1 (MUL) or T+DIV_LAT+1 (DIV).
- MTHI at edge T followed by MFHI in cycle T+1 reads the new HI, because the MDU writes HI at edge T.
- If mdu_busy stays high after cnt reaches 0, the unit keeps stalling. The counter is a lower bound only and never a timeout.

## Structure
- mdu_pkg holds the ex_cmd encodings, the mdu_op encodings, and the MUL_LAT/DIV_LAT defaults.
- One sub-module, mdu_lat_cnt: a loadable down-counter that saturates at 0 and outputs a zero flag.

## Test plan
- MULT rs=-3, rt=7, then MFLO next cycle:
  - mdu_op=01 and mdu_start pulses for 1 cycle.
  - stall_o is high for 4 cycles.
  - mf_data=0xFFFFFFEB and mf_valid=1 in cycle 6.
- DIVU 100/7, then MFHI:
  - stall_o is high for 9 cycles.
  - mf_data=2; MFLO then gives 14.
- MTLO rs=0x1234, then MFLO next cycle: no stall, mf_data=0x1234.
- MULT with ex_exc=1: mdu_start=0, mdu_if_exception=1, state stays IDLE, and HI/LO are unchanged.
- DIV in flight, then MULT presented in EX:
  - The MULT stalls until `done`, then issues in the exit cycle with no bubble.
  - A flush during WAIT keeps the unit in WAIT until `done`.
- resetn low in the 2nd cycle of WAIT: state returns to IDLE and cnt=0 immediately, without waiting for a clock edge.
